stream_fifo_buffer: RTL and testbench

STREAM_FIFO_BUFFER -- requirements
Module: stream_fifo_buffer

---
 rtl/stream_fifo_buffer.sv | 82 ++++++++
 tb/tb_stream_fifo_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stream_fifo_buffer.sv
// First-word-fall-through circular FIFO: a word pushed into an empty buffer is on out_data one cycle later.
// Backpressure: in_ready is registered (level < DEPTH) and never depends combinationally on out_ready or in_valid.
module stream_fifo_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  logic          almost_full_q, almost_full_d;
  logic          push, pop;

  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign in_ready    = in_ready_q;
  assign almost_full = almost_full_q;
  assign level       = level_q;

  always_comb begin
    push          = in_valid && in_ready_q;
    pop           = out_valid && out_ready;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    if (flush) begin
      // Flush wins over any handshake on the same edge.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      level_d = LW'(level_q + LW'(push) - LW'(pop));
    end
    // Derived from the next level so the flags match level in the same cycle.
    in_ready_d    = (level_d < DEPTH_L);
    almost_full_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// Directed bench for stream_fifo_buffer (DATA_WIDTH=8, DEPTH=4, AFULL_LEVEL=3).
module tb_stream_fifo_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       almost_full;

  int checks = 0;
  int errors = 0;

  stream_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic [2:0] lv;
    logic [7:0] od;
    logic       ir;
    logic       af;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic fl, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic [2:0] lv, input logic [7:0] od,
                              input logic ir, input logic af);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.lv = lv; v.od = od; v.ir = ir; v.af = af;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] lv, input logic [7:0] od,
                             input logic ir, input logic af);
    check({tag, " level"}, 32'(level), 32'(lv));
    check({tag, " out_valid"}, 32'(out_valid), 32'(lv != 3'd0));
    check({tag, " in_ready"}, 32'(in_ready), 32'(ir));
    check({tag, " almost_full"}, 32'(almost_full), 32'(af));
    if (lv != 3'd0) check({tag, " out_data"}, 32'(out_data), 32'(od));
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Vectors: flush, in_valid, in_data, out_ready -> level, out_data, in_ready, almost_full
    add(0, 1, 8'h11, 0, 3'd1, 8'h11, 1, 0);
    add(0, 1, 8'h22, 0, 3'd2, 8'h11, 1, 0);
    add(0, 1, 8'h33, 0, 3'd3, 8'h11, 1, 1);
    add(0, 0, 8'h00, 1, 3'd2, 8'h22, 1, 0);
    add(0, 0, 8'h00, 1, 3'd1, 8'h33, 1, 0);
    add(0, 0, 8'h00, 1, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'hA0, 0, 3'd1, 8'hA0, 1, 0);
    add(0, 1, 8'hA1, 0, 3'd2, 8'hA0, 1, 0);
    add(0, 1, 8'hA2, 0, 3'd3, 8'hA0, 1, 1);
    add(0, 1, 8'hA3, 0, 3'd4, 8'hA0, 0, 1);
    add(0, 1, 8'hFF, 0, 3'd4, 8'hA0, 0, 1);
    add(0, 1, 8'hFF, 0, 3'd4, 8'hA0, 0, 1);
    add(0, 1, 8'hFF, 0, 3'd4, 8'hA0, 0, 1);
    add(0, 1, 8'hFF, 1, 3'd3, 8'hA1, 1, 1);
    add(0, 0, 8'h00, 1, 3'd2, 8'hA2, 1, 0);
    add(0, 0, 8'h00, 1, 3'd1, 8'hA3, 1, 0);
    add(0, 0, 8'h00, 1, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'h55, 0, 3'd1, 8'h55, 1, 0);
    add(0, 1, 8'h66, 1, 3'd1, 8'h66, 1, 0);
    add(0, 1, 8'h77, 1, 3'd1, 8'h77, 1, 0);
    add(0, 0, 8'h00, 1, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'h01, 0, 3'd1, 8'h01, 1, 0);
    add(0, 1, 8'h02, 0, 3'd2, 8'h01, 1, 0);
    add(0, 1, 8'h03, 0, 3'd3, 8'h01, 1, 1);
    add(1, 1, 8'h04, 1, 3'd0, 8'h00, 1, 0);
    add(0, 1, 8'h05, 0, 3'd1, 8'h05, 1, 0);
    add(0, 0, 8'h00, 1, 3'd0, 8'h00, 1, 0);

    #12;
    check_state("reset", 3'd0, 8'h00, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_state("first edge", 3'd0, 8'h00, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      check_state($sformatf("vec%0d", i), vecs[i].lv, vecs[i].od, vecs[i].ir, vecs[i].af);
    end

    // Continuous stream of 20 words: level stays 1, output lags input by one edge.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'(i), 1);
      check_state($sformatf("stream%0d", i), 3'd1, 8'(i), 1, 0);
    end
    drive(0, 0, 8'h00, 1);
    check_state("stream drain", 3'd0, 8'h00, 1, 0);

    // Asynchronous reset between edges at level 2.
    drive(0, 1, 8'hC1, 0);
    drive(0, 1, 8'hC2, 0);
    check_state("pre-reset", 3'd2, 8'hC1, 1, 0);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_state("async reset", 3'd0, 8'h00, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_state("post-reset edge", 3'd0, 8'h00, 1, 0);
    drive(0, 1, 8'hD0, 0);
    check_state("post-reset push", 3'd1, 8'hD0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
